// File: rtl/mac_pkt_loopback.sv
// Single-clock AXIS packet buffer looping MAC RX frames back to MAC TX.
// Store-and-forward drops errored/oversize frames; cut-through back-pressures RX.
module mac_pkt_loopback #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 11,
  parameter int STORE_FWD      = 1,
  parameter int ALMFULL_MARGIN = 3
) (
  input  logic                  axis_clk,
  input  logic                  axis_rstn,
  input  logic [DATA_WIDTH-1:0] rx_axis_mac_tdata,
  input  logic                  rx_axis_mac_tvalid,
  input  logic                  rx_axis_mac_tlast,
  input  logic                  rx_axis_mac_tuser,
  output logic                  rx_axis_mac_tready,
  output logic [DATA_WIDTH-1:0] tx_axis_mac_tdata,
  output logic                  tx_axis_mac_tvalid,
  output logic                  tx_axis_mac_tlast,
  output logic                  tx_axis_mac_tuser,
  input  logic                  tx_axis_mac_tready,
  output logic [31:0]           frame_cnt,
  output logic [31:0]           drop_cnt,
  output logic [ADDR_WIDTH:0]   fifo_level
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int EW    = DATA_WIDTH + 2;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam bit SF    = (STORE_FWD != 0);

  localparam logic [PW-1:0] DEPTH_P  = PW'(DEPTH);
  localparam logic [PW-1:0] MARGIN_P = PW'(ALMFULL_MARGIN);
  localparam logic [PW-1:0] ONE_P    = PW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_DISCARD
  } wr_state_e;

  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] rd_word;

  logic [PW-1:0] wr_tmp_q, wr_tmp_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  wr_state_e     state_q, state_d;
  logic [31:0]   frame_cnt_q, frame_cnt_d;
  logic [31:0]   drop_cnt_q, drop_cnt_d;
  logic          rx_rdy_q, rx_rdy_d;

  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic tx_valid_q, tx_valid_d;
  logic tx_last_q, tx_last_d;
  logic tx_user_q, tx_user_d;

  logic          rx_acc, full, rd_en, mem_we;
  logic [PW-1:0] used, used_nxt, free_nxt;

  assign used    = wr_tmp_q - rd_ptr_q;
  assign full    = (used == DEPTH_P);
  assign rx_acc  = rx_axis_mac_tvalid && rx_rdy_q;
  assign rd_en   = (wr_ptr_q != rd_ptr_q)
                && (!tx_valid_q || tx_axis_mac_tready);
  assign rd_word = mem[rd_ptr_q[ADDR_WIDTH-1:0]];

  always_comb begin
    wr_tmp_d    = wr_tmp_q;
    wr_ptr_d    = wr_ptr_q;
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    mem_we      = 1'b0;
    if (!SF) begin
      if (rx_acc && !full) begin
        mem_we   = 1'b1;
        wr_tmp_d = wr_tmp_q + ONE_P;
        if (rx_axis_mac_tlast)
          frame_cnt_d = frame_cnt_q + 32'd1;
      end
      wr_ptr_d = wr_tmp_d;
    end else if (rx_acc) begin
      if (state_q == S_DISCARD) begin
        if (rx_axis_mac_tlast) begin
          drop_cnt_d = drop_cnt_q + 32'd1;
          state_d    = S_IDLE;
        end
      end else if (full) begin
        // oversize frame: roll back and swallow the rest of it
        wr_tmp_d = wr_ptr_q;
        if (rx_axis_mac_tlast) begin
          drop_cnt_d = drop_cnt_q + 32'd1;
          state_d    = S_IDLE;
        end else begin
          state_d = S_DISCARD;
        end
      end else begin
        mem_we   = 1'b1;
        wr_tmp_d = wr_tmp_q + ONE_P;
        state_d  = S_WRITE;
        if (rx_axis_mac_tlast && rx_axis_mac_tuser) begin
          wr_tmp_d   = wr_ptr_q;
          drop_cnt_d = drop_cnt_q + 32'd1;
          state_d    = S_IDLE;
        end else if (rx_axis_mac_tlast) begin
          wr_ptr_d    = wr_tmp_q + ONE_P;
          frame_cnt_d = frame_cnt_q + 32'd1;
          state_d     = S_IDLE;
        end
      end
    end
  end

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    tx_last_d  = tx_last_q;
    tx_user_d  = tx_user_q;
    if (rd_en) begin
      rd_ptr_d   = rd_ptr_q + ONE_P;
      tx_valid_d = 1'b1;
      tx_data_d  = rd_word[DATA_WIDTH-1:0];
      tx_last_d  = rd_word[DATA_WIDTH];
      tx_user_d  = !SF && rd_word[DATA_WIDTH]
                && rd_word[DATA_WIDTH+1];
    end else if (tx_axis_mac_tready) begin
      tx_valid_d = 1'b0;
      tx_data_d  = '0;
      tx_last_d  = 1'b0;
      tx_user_d  = 1'b0;
    end
  end

  // CT ready looks at occupancy after this cycle's read and write
  always_comb begin
    used_nxt = wr_tmp_d - rd_ptr_d;
    free_nxt = DEPTH_P - used_nxt;
    rx_rdy_d = SF ? 1'b1 : (free_nxt > MARGIN_P);
  end

  always_ff @(posedge axis_clk) begin
    if (mem_we)
      mem[wr_tmp_q[ADDR_WIDTH-1:0]] <= {rx_axis_mac_tuser,
                                        rx_axis_mac_tlast,
                                        rx_axis_mac_tdata};
  end

  always_ff @(posedge axis_clk or negedge axis_rstn) begin
    if (!axis_rstn) begin
      wr_tmp_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      state_q     <= S_IDLE;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
      rx_rdy_q    <= 1'b0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      tx_last_q   <= 1'b0;
      tx_user_q   <= 1'b0;
    end else begin
      wr_tmp_q    <= wr_tmp_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      rx_rdy_q    <= rx_rdy_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      tx_last_q   <= tx_last_d;
      tx_user_q   <= tx_user_d;
    end
  end

  assign rx_axis_mac_tready = rx_rdy_q;
  assign tx_axis_mac_tdata  = tx_data_q;
  assign tx_axis_mac_tvalid = tx_valid_q;
  assign tx_axis_mac_tlast  = tx_last_q;
  assign tx_axis_mac_tuser  = tx_user_q;
  assign frame_cnt          = frame_cnt_q;
  assign drop_cnt           = drop_cnt_q;
  assign fifo_level         = used;

endmodule

// File: tb/tb_mac_pkt_loopback.sv
// Directed bench for mac_pkt_loopback: an SF instance (64 deep)
// and a CT instance (16 deep) share stimulus; a monitor scores TX.
module tb_mac_pkt_loopback;

  localparam int SAW = 6;
  localparam int CAW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] rx_data = '0;
  logic rx_valid = 1'b0;
  logic rx_last = 1'b0;
  logic rx_user = 1'b0;
  logic tx_rdy = 1'b0;
  logic sel_ct = 1'b0;
  logic rand_rdy = 1'b0;

  logic sf_rx_rdy, sf_txv, sf_txl, sf_txu;
  logic [7:0] sf_txd;
  logic [31:0] sf_fc, sf_dc;
  logic [SAW:0] sf_lvl;
  logic ct_rx_rdy, ct_txv, ct_txl, ct_txu;
  logic [7:0] ct_txd;
  logic [31:0] ct_fc, ct_dc;
  logic [CAW:0] ct_lvl;

  logic rdy, txv, txl, txu;
  logic [7:0] txd;
  logic [31:0] lvl;

  int vectors = 0;
  int miscompares = 0;
  logic [9:0] expq[$];
  logic [7:0] fr[$];

  mac_pkt_loopback #(
    .DATA_WIDTH(8), .ADDR_WIDTH(SAW),
    .STORE_FWD(1), .ALMFULL_MARGIN(3)
  ) u_sf (
    .axis_clk(clk), .axis_rstn(rst_n),
    .rx_axis_mac_tdata(rx_data),
    .rx_axis_mac_tvalid(rx_valid & ~sel_ct),
    .rx_axis_mac_tlast(rx_last),
    .rx_axis_mac_tuser(rx_user),
    .rx_axis_mac_tready(sf_rx_rdy),
    .tx_axis_mac_tdata(sf_txd),
    .tx_axis_mac_tvalid(sf_txv),
    .tx_axis_mac_tlast(sf_txl),
    .tx_axis_mac_tuser(sf_txu),
    .tx_axis_mac_tready(tx_rdy),
    .frame_cnt(sf_fc), .drop_cnt(sf_dc),
    .fifo_level(sf_lvl)
  );

  mac_pkt_loopback #(
    .DATA_WIDTH(8), .ADDR_WIDTH(CAW),
    .STORE_FWD(0), .ALMFULL_MARGIN(3)
  ) u_ct (
    .axis_clk(clk), .axis_rstn(rst_n),
    .rx_axis_mac_tdata(rx_data),
    .rx_axis_mac_tvalid(rx_valid & sel_ct),
    .rx_axis_mac_tlast(rx_last),
    .rx_axis_mac_tuser(rx_user),
    .rx_axis_mac_tready(ct_rx_rdy),
    .tx_axis_mac_tdata(ct_txd),
    .tx_axis_mac_tvalid(ct_txv),
    .tx_axis_mac_tlast(ct_txl),
    .tx_axis_mac_tuser(ct_txu),
    .tx_axis_mac_tready(tx_rdy),
    .frame_cnt(ct_fc), .drop_cnt(ct_dc),
    .fifo_level(ct_lvl)
  );

  assign rdy = sel_ct ? ct_rx_rdy : sf_rx_rdy;
  assign txv = sel_ct ? ct_txv : sf_txv;
  assign txl = sel_ct ? ct_txl : sf_txl;
  assign txu = sel_ct ? ct_txu : sf_txu;
  assign txd = sel_ct ? ct_txd : sf_txd;
  assign lvl = sel_ct ? 32'(ct_lvl) : 32'(sf_lvl);

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // a beat transfers at the next posedge when valid&&ready here
  always @(negedge clk) begin : mon
    logic [9:0] e;
    if (rst_n && txv && tx_rdy) begin
      if (expq.size() == 0) begin
        check("tx_extra", 32'(expq.size()), 32'd1);
      end else begin
        e = expq.pop_front();
        check("tx_beat", 32'({txu, txl, txd}), 32'(e));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rdy) tx_rdy = 1'($urandom_range(0, 1));
  endtask

  task automatic send_beat(input logic [7:0] d,
                           input logic l, input logic u);
    logic acc;
    int n;
    acc = 1'b0;
    n = 0;
    rx_data = d;
    rx_last = l;
    rx_user = u;
    rx_valid = 1'b1;
    while (!acc && n < 2000) begin
      @(negedge clk);
      acc = rdy;
      step();
      n++;
    end
    rx_valid = 1'b0;
    if (!acc) check("rx_accept", 32'(acc), 32'd1);
  endtask

  task automatic send_frame(input logic err, input logic keep);
    logic l;
    for (int i = 0; i < fr.size(); i++) begin
      l = (i == fr.size() - 1);
      if (keep) expq.push_back({sel_ct & err & l, l, fr[i]});
      send_beat(fr[i], l, err & l);
    end
  endtask

  task automatic fill(input int len, input logic [7:0] base,
                      input logic rnd);
    fr.delete();
    for (int i = 0; i < len; i++)
      fr.push_back(rnd ? 8'($urandom_range(0, 255))
                       : 8'(32'(base) + i));
  endtask

  task automatic drain();
    int n;
    n = 0;
    if (!rand_rdy) tx_rdy = 1'b1;
    while ((expq.size() != 0 || lvl != 0 || txv) && n < 5000) begin
      step();
      n++;
    end
    check("drain", 32'(expq.size()), 32'd0);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int sent;
    int maxl;
    int len;
    logic acc;
    logic err;
    logic keep;
    int good;
    int bad;

    // reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_sf_rdy", 32'(sf_rx_rdy), 32'd0);
    check("rst_sf_txv", 32'(sf_txv), 32'd0);
    check("rst_sf_fc", sf_fc, 32'd0);
    check("rst_sf_lvl", 32'(sf_lvl), 32'd0);
    check("rst_ct_rdy", 32'(ct_rx_rdy), 32'd0);
    check("rst_ct_txd", 32'(ct_txd), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_sf_rdy", 32'(sf_rx_rdy), 32'd1);
    check("rel_ct_rdy", 32'(ct_rx_rdy), 32'd1);

    // SF 64-beat good frame fills the buffer exactly
    tx_rdy = 1'b1;
    fill(64, 8'h00, 1'b0);
    send_frame(1'b0, 1'b1);
    check("t1_full_lvl", 32'(sf_lvl), 32'd64);
    check("t1_txv_early", 32'(sf_txv), 32'd0);
    check("t1_fc", sf_fc, 32'd1);
    step();
    check("t1_txv", 32'(sf_txv), 32'd1);
    check("t1_first", 32'(sf_txd), 32'h00);
    drain();

    // SF errored frame disappears
    fill(32, 8'h80, 1'b0);
    send_frame(1'b1, 1'b0);
    check("t2_lvl", 32'(sf_lvl), 32'd0);
    check("t2_dc", sf_dc, 32'd1);
    repeat (5) step();
    check("t2_txv", 32'(sf_txv), 32'd0);
    check("t2_fc", sf_fc, 32'd1);

    // SF oversize: 65 beats (tlast on full), 70 beats (discard)
    fill(65, 8'h10, 1'b0);
    send_frame(1'b0, 1'b0);
    check("t3_dc65", sf_dc, 32'd2);
    check("t3_lvl65", 32'(sf_lvl), 32'd0);
    fill(70, 8'h20, 1'b0);
    send_frame(1'b0, 1'b0);
    check("t3_dc70", sf_dc, 32'd3);
    fill(8, 8'hC0, 1'b0);
    send_frame(1'b0, 1'b1);
    drain();
    check("t3_fc", sf_fc, 32'd2);
    check("t3_dc", sf_dc, 32'd3);

    // CT back-pressure with TX stalled
    sel_ct = 1'b1;
    tx_rdy = 1'b0;
    sent = 0;
    maxl = 0;
    rx_valid = 1'b1;
    repeat (30) begin
      rx_data = 8'(160 + sent);
      rx_last = (sent % 5 == 4);
      rx_user = (sent == 9);
      @(negedge clk);
      acc = ct_rx_rdy;
      step();
      if (acc) begin
        expq.push_back({rx_user & rx_last, rx_last, rx_data});
        sent++;
      end
      if (int'(ct_lvl) > maxl) maxl = int'(ct_lvl);
    end
    rx_valid = 1'b0;
    check("t4_sent", 32'(sent), 32'd14);
    check("t4_maxlvl", 32'(maxl), 32'd13);
    check("t4_rdy_low", 32'(ct_rx_rdy), 32'd0);
    drain();
    check("t4_fc", ct_fc, 32'd2);
    check("t4_dc", ct_dc, 32'd0);
    check("t4_rdy_back", 32'(ct_rx_rdy), 32'd1);

    // CT random back-to-back frames, random TX ready
    rand_rdy = 1'b1;
    for (int f = 0; f < 20; f++) begin
      len = $urandom_range(1, 300);
      err = 1'($urandom_range(0, 1));
      fill(len, 8'h00, 1'b1);
      send_frame(err, 1'b1);
    end
    drain();
    check("t5_ct_fc", ct_fc, 32'd22);
    check("t5_ct_dc", ct_dc, 32'd0);

    // SF random frames, each started on an empty buffer
    sel_ct = 1'b0;
    good = 0;
    bad = 0;
    for (int f = 0; f < 20; f++) begin
      len = $urandom_range(1, 80);
      err = ($urandom_range(0, 3) == 0);
      keep = (len <= 64) && !err;
      if (keep) good++;
      else bad++;
      fill(len, 8'h00, 1'b1);
      drain();
      send_frame(err, keep);
    end
    drain();
    check("t5_sf_fc", sf_fc, 32'(2 + good));
    check("t5_sf_dc", sf_dc, 32'(3 + bad));

    // reset mid-frame while TX holds a beat
    rand_rdy = 1'b0;
    tx_rdy = 1'b0;
    fill(10, 8'h50, 1'b0);
    send_frame(1'b0, 1'b1);
    step();
    check("t6_busy", 32'(sf_txv), 32'd1);
    check("t6_busy_d", 32'(sf_txd), 32'h50);
    for (int i = 0; i < 5; i++)
      send_beat(8'(8'h60 + i), 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("t6_txv", 32'(sf_txv), 32'd0);
    check("t6_txd", 32'(sf_txd), 32'd0);
    check("t6_rdy", 32'(sf_rx_rdy), 32'd0);
    check("t6_lvl", 32'(sf_lvl), 32'd0);
    check("t6_fc", sf_fc, 32'd0);
    check("t6_ct_fc", ct_fc, 32'd0);
    expq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("t6_rdy_rel", 32'(sf_rx_rdy), 32'd1);
    tx_rdy = 1'b1;
    fill(6, 8'h70, 1'b0);
    send_frame(1'b0, 1'b1);
    drain();
    check("t6_fc_new", sf_fc, 32'd1);
    check("t6_dc_new", sf_dc, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
